// File: rtl/grf_scoreboard.sv
// Parametrised general register file with write-through bypass and a pending-write scoreboard.
// Optional WRITE_TRACE_EN macro enables a simulation-only writeback trace display.
module grf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [31:0]                wr_pc,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_hit, iss_hit, set_new, clr_real;
  logic [ADDR_W-1:0] ra;

  // Next-state for storage, pending bits and the incremental popcount; set beats clear.
  always_comb begin
    wr_hit   = wr_en && (wr_addr != '0);
    iss_hit  = iss_en && (iss_addr != '0);
    regs_d   = regs_q;
    pend_d   = pend_q;
    set_new  = iss_hit && !pend_q[iss_addr];
    clr_real = wr_hit && pend_q[wr_addr] && !(iss_hit && (iss_addr == wr_addr));
    if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (iss_hit) begin
      pend_d[iss_addr] = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_real);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports: a same-cycle writeback both forwards data and releases the stall.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (ra != '0) begin
        if (wr_en && (ra == wr_addr)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
          rd_pend[k]                  = pend_q[ra];
        end
      end
    end
  end

  assign pend_cnt = cnt_q;

`ifdef WRITE_TRACE_EN
  always @(posedge clk) begin
    if (!reset && wr_en && (wr_addr != '0)) begin
      $display("@%08h: $%2d <= %h", wr_pc, wr_addr, wr_data);
    end
  end
`else
  logic wr_pc_unused;
  assign wr_pc_unused = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: default 32x32/2-port instance plus a 16-bit, 8-entry, 4-port instance.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        wr_en, iss_en;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data, wr_pc;
  logic [5:0]  pend_cnt;

  logic [11:0] rd_addr4;
  logic [63:0] rd_data4;
  logic [3:0]  rd_pend4;
  logic        wr_en4, iss_en4;
  logic [2:0]  wr_addr4, iss_addr4;
  logic [15:0] wr_data4;
  logic [31:0] wr_pc4;
  logic [3:0]  pend_cnt4;

  grf_scoreboard u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  grf_scoreboard #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_dut4 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_pend(rd_pend4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_pc(wr_pc4),
    .iss_en(iss_en4), .iss_addr(iss_addr4), .pend_cnt(pend_cnt4)
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [63:0] data;
    logic [3:0]  pend;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] v4 [8];

  // Monitor: every expectation queued this cycle is compared against the DUT away from the edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] ad;
    logic [3:0]  ap;
    logic [5:0]  ac;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e.sel) begin
        ad = rd_data;  ap = {2'b00, rd_pend};  ac = pend_cnt;
      end else begin
        ad = rd_data4; ap = rd_pend4;          ac = {2'b00, pend_cnt4};
      end
      checks++;
      if (ad !== e.data) begin
        errors++;
        $display("FAIL %s rd_data: got %h expected %h", e.name, ad, e.data);
      end
      checks++;
      if (ap !== e.pend) begin
        errors++;
        $display("FAIL %s rd_pend: got %b expected %b", e.name, ap, e.pend);
      end
      checks++;
      if (ac !== e.cnt) begin
        errors++;
        $display("FAIL %s pend_cnt: got %0d expected %0d", e.name, ac, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr = {ra1, ra0};
  endtask

  task automatic exp0(input string n, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] p, input logic [5:0] c);
    exp_t e;
    e.name = n; e.sel = 1'b0; e.data = {d1, d0}; e.pend = {2'b00, p}; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic exp4(input string n, input logic [63:0] d, input logic [3:0] p,
                      input logic [3:0] c);
    exp_t e;
    e.name = n; e.sel = 1'b1; e.data = d; e.pend = p; e.cnt = {2'b00, c};
    exp_q.push_back(e);
  endtask

  initial begin
    v4[0] = 16'h0000; v4[1] = 16'h0042; v4[2] = 16'h1102; v4[3] = 16'h2203;
    v4[4] = 16'h3304; v4[5] = 16'h4405; v4[6] = 16'h5506; v4[7] = 16'h6607;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    wr_pc = 32'h0;
    rd_addr4 = '0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; wr_pc4 = '0;
    iss_en4 = 1'b0; iss_addr4 = '0;

    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
    exp0("reset_state", 32'h0, 32'h0, 2'b00, 6'd0);
    tick();
    reset = 1'b0;

    // Write $5 with an issue to 9, then assert reset asynchronously mid-cycle.
    tick();
    drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd9, 5'd5, 5'd5);
    exp0("wr5_bypass", 32'h1234, 32'h1234, 2'b00, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    exp0("wr5_stored", 32'h1234, 32'h0, 2'b10, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    #1 reset = 1'b1;
    exp0("async_reset", 32'h0, 32'h0, 2'b00, 6'd0);
    tick();
    reset = 1'b0;

    // Issue 8, stall, then same-cycle writeback releases it.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd0, 5'd8);
    exp0("iss8_same_cycle", 32'h0, 32'h0, 2'b00, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd8);
    exp0("iss8_pending", 32'h0, 32'h0, 2'b10, 6'd1);
    tick();
    drive(1'b1, 5'd8, 32'hCAFEBABE, 1'b0, 5'd0, 5'd0, 5'd8);
    exp0("wb8_release", 32'h0, 32'hCAFEBABE, 2'b00, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd8);
    exp0("wb8_after", 32'hCAFEBABE, 32'hCAFEBABE, 2'b00, 6'd0);
    tick();

    // Issue and writeback hitting the same pending register: set wins.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    exp0("iss3_pending", 32'h0, 32'h0, 2'b01, 6'd1);
    tick();
    drive(1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 5'd3, 5'd3);
    exp0("iss_wb3_same", 32'd7, 32'd7, 2'b00, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    exp0("iss_wb3_after", 32'd7, 32'd7, 2'b11, 6'd1);
    tick();
    drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd0);
    exp0("wb3_clear", 32'h55, 32'h0, 2'b00, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    exp0("wb3_after", 32'h55, 32'h0, 2'b00, 6'd0);
    tick();

    // Register 0 ignores writes and issues.
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    exp0("r0_same", 32'h0, 32'h0, 2'b00, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    exp0("r0_after", 32'h0, 32'h0, 2'b00, 6'd0);
    tick();

    // Issue and real clear on different registers: net zero.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 5'd4, 5'd6);
    exp0("net0_same", 32'h44, 32'h0, 2'b00, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    exp0("net0_after", 32'h44, 32'h0, 2'b10, 6'd1);
    tick();
    drive(1'b1, 5'd6, 32'h60, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    // Fill the scoreboard, re-issue a pending register, then drain it.
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
      exp0("fill_cnt", 32'h0, 32'h0, 2'b00, 6'(a - 1));
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd1, 5'd31);
    exp0("full", 32'h0, 32'h0, 2'b11, 6'd31);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
    exp0("reissue_full", 32'h0, 32'hCAFEBABE, 2'b11, 6'd31);
    tick();
    for (int a = 1; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'(a * 16), 1'b0, 5'd0, 5'(a), 5'd0);
      exp0("drain", 32'(a * 16), 32'h0, 2'b00, 6'(32 - a));
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);
    exp0("drained", 32'd16, 32'd496, 2'b00, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Four-port instance: fill regs 1..7 (bypass on every port), then concurrent reads.
    for (int a = 1; a < 8; a++) begin
      wr_en4 = 1'b1; wr_addr4 = 3'(a); wr_data4 = v4[a];
      wr_pc4 = 32'h3000 + 32'((a - 1) * 4);
      rd_addr4 = {4{3'(a)}};
      exp4("p4_write", {4{v4[a]}}, 4'b0000, 4'd0);
      tick();
    end
    wr_en4 = 1'b0;
    rd_addr4 = {3'd2, 3'd4, 3'd1, 3'd7};
    iss_en4 = 1'b1; iss_addr4 = 3'd5;
    exp4("p4_read_a", {v4[2], v4[4], v4[1], v4[7]}, 4'b0000, 4'd0);
    tick();
    iss_en4 = 1'b0;
    rd_addr4 = {3'd1, 3'd6, 3'd3, 3'd5};
    exp4("p4_read_b", {v4[1], v4[6], v4[3], v4[5]}, 4'b0001, 4'd1);
    tick();
    rd_addr4 = {3'd0, 3'd5, 3'd5, 3'd2};
    wr_en4 = 1'b1; wr_addr4 = 3'd5; wr_data4 = 16'hBEEF;
    exp4("p4_wb_release", {16'h0, 16'hBEEF, 16'hBEEF, v4[2]}, 4'b0000, 4'd1);
    tick();
    wr_en4 = 1'b0;
    exp4("p4_after", {16'h0, 16'hBEEF, 16'hBEEF, v4[2]}, 4'b0000, 4'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU, replacing the fixed 32x32, two-read-port GRF.
- Adds configurable width, depth and read-port count, plus an internal pending-write scoreboard.
- The decode stage uses the scoreboard to stall on in-flight producers.
- Sits in D stage: reads at decode, issue marks at decode, writeback from W stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears registers and scoreboard
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
rd_pend  out  NUM_RD  port k operand not yet available (stall request)
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
wr_pc  in  32  PC of writing instruction (trace only)
iss_en  in  1  instruction with destination issued this cycle
iss_addr  in  ADDR_W  destination of issued instruction
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers plus one pending bit per register.
- Reset:
  - Asserting reset clears, without waiting for clk, all registers, all pending bits and pend_cnt.
  - Outputs then read 0 and rd_pend = 0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards all in-flight marks.
- Register 0:
  - Always reads 0 and is never pending.
  - Writes or issues to address 0 are ignored and pend_cnt is unchanged.
- Write: on the rising edge with wr_en=1 and wr_addr!=0, register[wr_addr] <= wr_data.
- Read (combinational), per port k:
  - addr==0 -> 0.
  - Else if wr_en and addr==wr_addr -> wr_data (write-through bypass, same cycle).
  - Else register[addr].
- rd_pend[k] (combinational):
  - 1 iff addr!=0, pending[addr]=1, and not (wr_en and wr_addr==addr).
  - A same-cycle writeback releases the stall.
- Scoreboard update, per rising edge, for address a != 0:
  - iss_en and iss_addr==a sets pending[a].
  - wr_en and wr_addr==a clears pending[a].
  - Both on the same a: set wins (newer producer outstanding).
  - Issue to an already-pending register: bit stays 1, count unchanged.
  - Writeback to a non-pending register: plain write, count unchanged.
- pend_cnt: registered popcount of pending bits, updated incrementally each edge.
  - +1 for a new set, -1 for a real clear, net 0 when both hit different registers.
  - Range 0..2**ADDR_W-1; never wraps.
- Read and scoreboard outputs are valid in the same cycle as inputs. Write and scoreboard effects are visible after the edge, except the bypass.

Optional Feature:
WRITE_TRACE_EN
- Defined: on every rising edge with wr_en=1, !reset and wr_addr!=0, the block displays "@<wr_pc hex 8>: $<wr_addr decimal 2> <= <wr_data hex>".
  - Display is simulation only.
- Undefined: no display; wr_pc is unused and synthesises away.
- Functional behaviour is identical either way.

Test Plan:
- Assert reset asynchronously mid-cycle after writing $5=0x1234 -> rd_data port0 (addr 5) reads 0 before the next edge; pend_cnt=0.
- iss_en addr 8, then next cycle read addr 8 on port1 -> rd_pend[1]=1, pend_cnt=1; wr_en addr 8 data 0xCAFEBABE same cycle as read -> rd_pend[1]=0, rd_data=0xCAFEBABE; after edge pend_cnt=0.
- Same edge iss_en addr 3 and wr_en addr 3 data 7 (3 pending) -> register[3]=7, pending[3] stays 1, pend_cnt unchanged.
- iss_en addr 0 and wr_en addr 0 data 0xFFFF -> addr 0 reads 0, rd_pend 0, pend_cnt 0.
- Issue to every nonzero register over 31 cycles -> pend_cnt=31; write all back -> pend_cnt=0, no wrap.
- NUM_RD=4, DATA_W=16, ADDR_W=3: write distinct values to regs 1..7, read 4 different addresses concurrently -> each port returns its own value. With WRITE_TRACE_EN, wr_pc=0x00003000 writing $1=0x0042 prints "@00003000: $ 1 <= 0042".
